// File: rtl/mem_arbiter_if.sv
// Bundle between mem_arbiter and its neighbours: IF/LS request channels, flush and the byte-wide RAM/IO bus.
// master = arbiter side, slave = requesters plus memory.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  clear_in;
  logic                  if_req_in;
  logic [ADDR_WIDTH-1:0] if_addr_in;
  logic                  if_done_out;
  logic [31:0]           if_data_out;
  logic                  ls_req_in;
  logic                  ls_wr_in;
  logic [ADDR_WIDTH-1:0] ls_addr_in;
  logic [2:0]            ls_size_in;
  logic [31:0]           ls_wdata_in;
  logic                  ls_done_out;
  logic [31:0]           ls_rdata_out;
  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;
  logic                  io_buffer_full;

  modport master (
    input  clear_in, if_req_in, if_addr_in, ls_req_in, ls_wr_in, ls_addr_in,
           ls_size_in, ls_wdata_in, mem_din, io_buffer_full,
    output if_done_out, if_data_out, ls_done_out, ls_rdata_out, mem_dout, mem_a, mem_wr
  );

  modport slave (
    output clear_in, if_req_in, if_addr_in, ls_req_in, ls_wr_in, ls_addr_in,
           ls_size_in, ls_wdata_in, mem_din, io_buffer_full,
    input  if_done_out, if_data_out, ls_done_out, ls_rdata_out, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM/IO port between instruction fetch and the load/store buffer.
// Define MEM_ARB_RR_EN for round-robin arbitration on contention; default is fixed LS > IF.
module mem_arbiter #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(32'h0003_0000)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state_q, state_n;
  logic                  owner_ls_q, owner_ls_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [2:0]            nbytes_q, nbytes_n;
  logic [31:0]           wdata_q, wdata_n;
  logic [2:0]            cnt_q, cnt_n;
  logic [31:0]           buf_q, buf_n;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_n;
  logic [7:0]            mem_dout_q, mem_dout_n;
  logic                  mem_wr_q, mem_wr_n;
  logic                  if_done_q, if_done_n;
  logic [31:0]           if_data_q, if_data_n;
  logic                  ls_done_q, ls_done_n;
  logic [31:0]           ls_rdata_q, ls_rdata_n;

  logic                  grant_ls;
  logic                  can_grant;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [ADDR_WIDTH-1:0] next_a;
  logic [1:0]            ridx;
  logic [1:0]            widx;

  function automatic logic [2:0] size_bytes(input logic [2:0] s);
    case (s)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign can_grant = (state_q == IDLE || state_q == DONE) && !bus.clear_in;

`ifdef MEM_ARB_RR_EN
  // Only contended grants update the history, so sequential service after a conflict
  // does not flip the next tie-break.
  logic last_ls_q;
  assign grant_ls = bus.ls_req_in && !(bus.if_req_in && last_ls_q);
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      last_ls_q <= 1'b0;
    else if (can_grant && bus.ls_req_in && bus.if_req_in)
      last_ls_q <= grant_ls;
  end
`else
  assign grant_ls = bus.ls_req_in;
`endif

  assign sel_addr = grant_ls ? bus.ls_addr_in : bus.if_addr_in;
  assign next_a   = addr_q + ADDR_WIDTH'(cnt_q + 3'd1);
  assign ridx     = cnt_q[1:0] - 2'd1;
  assign widx     = cnt_q[1:0] + 2'd1;

  always_comb begin
    state_n    = state_q;
    owner_ls_n = owner_ls_q;
    addr_n     = addr_q;
    nbytes_n   = nbytes_q;
    wdata_n    = wdata_q;
    cnt_n      = cnt_q;
    buf_n      = buf_q;
    mem_a_n    = mem_a_q;
    mem_dout_n = mem_dout_q;
    mem_wr_n   = 1'b0;
    if_done_n  = 1'b0;
    if_data_n  = if_data_q;
    ls_done_n  = 1'b0;
    ls_rdata_n = ls_rdata_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_n = IDLE;
        if (can_grant && (bus.ls_req_in || bus.if_req_in)) begin
          owner_ls_n = grant_ls;
          addr_n     = sel_addr;
          nbytes_n   = grant_ls ? size_bytes(bus.ls_size_in) : 3'd4;
          wdata_n    = bus.ls_wdata_in;
          cnt_n      = '0;
          buf_n      = '0;
          mem_a_n    = sel_addr;
          if (grant_ls && bus.ls_wr_in) begin
            state_n    = WRITE;
            mem_dout_n = bus.ls_wdata_in[7:0];
            mem_wr_n   = !(sel_addr >= IO_BASE && bus.io_buffer_full);
          end else begin
            state_n = READ;
          end
        end
      end

      // cnt counts edges since grant: address byte cnt+1 goes out, byte cnt-1 comes back.
      READ: begin
        if (bus.clear_in) begin
          state_n = IDLE;
        end else begin
          if ((cnt_q + 3'd1) < nbytes_q)
            mem_a_n = next_a;
          if (cnt_q != 3'd0)
            buf_n[{ridx, 3'b000} +: 8] = bus.mem_din;
          if (cnt_q == nbytes_q) begin
            state_n = DONE;
            if (owner_ls_q) begin
              ls_done_n  = 1'b1;
              ls_rdata_n = buf_n;
            end else begin
              if_done_n = 1'b1;
              if_data_n = buf_n;
            end
          end
          cnt_n = cnt_q + 3'd1;
        end
      end

      // mem_wr_q high means byte cnt went out last cycle; low means it is being retried.
      WRITE: begin
        if (mem_wr_q) begin
          if ((cnt_q + 3'd1) == nbytes_q) begin
            state_n   = DONE;
            ls_done_n = 1'b1;
          end else begin
            cnt_n      = cnt_q + 3'd1;
            mem_a_n    = next_a;
            mem_dout_n = wdata_q[{widx, 3'b000} +: 8];
            mem_wr_n   = !(next_a >= IO_BASE && bus.io_buffer_full);
          end
        end else begin
          mem_wr_n = !(mem_a_q >= IO_BASE && bus.io_buffer_full);
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      owner_ls_q <= 1'b0;
      addr_q     <= '0;
      nbytes_q   <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      buf_q      <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_done_q  <= 1'b0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_n;
      owner_ls_q <= owner_ls_n;
      addr_q     <= addr_n;
      nbytes_q   <= nbytes_n;
      wdata_q    <= wdata_n;
      cnt_q      <= cnt_n;
      buf_q      <= buf_n;
      mem_a_q    <= mem_a_n;
      mem_dout_q <= mem_dout_n;
      mem_wr_q   <= mem_wr_n;
      if_done_q  <= if_done_n;
      if_data_q  <= if_data_n;
      ls_done_q  <= ls_done_n;
      ls_rdata_q <= ls_rdata_n;
    end
  end

  assign bus.mem_a        = mem_a_q;
  assign bus.mem_dout     = mem_dout_q;
  assign bus.mem_wr       = mem_wr_q;
  assign bus.if_done_out  = if_done_q;
  assign bus.if_data_out  = if_data_q;
  assign bus.ls_done_out  = ls_done_q;
  assign bus.ls_rdata_out = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single accesses plus hand sequences for
// contention, flush and asynchronous reset. RAM model returns the byte one cycle after its address.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ram_init = 1'b1;
  logic [7:0] ram [0:1023];
  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter_if #(.ADDR_WIDTH(32)) bus ();

  mem_arbiter #(.ADDR_WIDTH(32), .IO_BASE(32'h0003_0000)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
      ram[10'h100] <= 8'h13; ram[10'h101] <= 8'h05; ram[10'h102] <= 8'h00; ram[10'h103] <= 8'h00;
      ram[10'h104] <= 8'h78; ram[10'h105] <= 8'h56; ram[10'h106] <= 8'h34; ram[10'h107] <= 8'h12;
    end else if (bus.mem_wr) begin
      ram[bus.mem_a[9:0]] <= bus.mem_dout;
    end
    bus.mem_din <= ram[bus.mem_a[9:0]];
  end

  typedef struct {
    bit          is_ls;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          full_cyc;
    int          clr_edge;
    int          exp_lat;
    logic [31:0] exp_data;
    int          exp_wr;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(bit is_ls, bit wr, logic [31:0] addr, logic [2:0] size,
                              logic [31:0] wdata, int full_cyc, int clr_edge,
                              int exp_lat, logic [31:0] exp_data, int exp_wr);
    vec_t v;
    v.is_ls = is_ls; v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata;
    v.full_cyc = full_cyc; v.clr_edge = clr_edge; v.exp_lat = exp_lat;
    v.exp_data = exp_data; v.exp_wr = exp_wr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cnt;
    int wrc;
    bit seen;
    logic [31:0] data;
    cnt = -1; wrc = 0; seen = 1'b0; data = '0;
    @(negedge clk);
    if (v.is_ls) begin
      bus.ls_req_in = 1'b1; bus.ls_wr_in = v.wr; bus.ls_addr_in = v.addr;
      bus.ls_size_in = v.size; bus.ls_wdata_in = v.wdata;
    end else begin
      bus.if_req_in = 1'b1; bus.if_addr_in = v.addr;
    end
    bus.io_buffer_full = (v.full_cyc > 0);
    bus.clear_in = (v.clr_edge == 0);
    while (!seen && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      if (bus.mem_wr) wrc++;
      bus.io_buffer_full = (cnt + 1 < v.full_cyc);
      bus.clear_in = (cnt + 1 == v.clr_edge);
      if (v.is_ls ? bus.ls_done_out : bus.if_done_out) begin
        seen = 1'b1;
        data = v.is_ls ? bus.ls_rdata_out : bus.if_data_out;
        bus.ls_req_in = 1'b0;
        bus.if_req_in = 1'b0;
      end
    end
    bus.ls_req_in = 1'b0; bus.if_req_in = 1'b0;
    bus.clear_in = 1'b0; bus.io_buffer_full = 1'b0;
    check($sformatf("vec%0d_latency", idx), seen ? 32'(cnt) : 32'hFFFF_FFFF, 32'(v.exp_lat));
    if (!v.wr) check($sformatf("vec%0d_data", idx), data, v.exp_data);
    check($sformatf("vec%0d_wr_cycles", idx), 32'(wrc), 32'(v.exp_wr));
    @(posedge clk); #1;
    check($sformatf("vec%0d_done_pulse", idx), {30'b0, bus.ls_done_out, bus.if_done_out}, 32'h0);
  endtask

  task automatic contend(input bit exp_ls_first, input int idx);
    int cnt;
    int ls_at;
    int if_at;
    logic [31:0] ls_d;
    logic [31:0] if_d;
    cnt = -1; ls_at = -1; if_at = -1; ls_d = '0; if_d = '0;
    @(negedge clk);
    bus.if_req_in = 1'b1; bus.if_addr_in = 32'h100;
    bus.ls_req_in = 1'b1; bus.ls_wr_in = 1'b0; bus.ls_addr_in = 32'h104; bus.ls_size_in = 3'd1;
    while ((ls_at < 0 || if_at < 0) && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      if (bus.ls_done_out && ls_at < 0) begin ls_at = cnt; ls_d = bus.ls_rdata_out; bus.ls_req_in = 1'b0; end
      if (bus.if_done_out && if_at < 0) begin if_at = cnt; if_d = bus.if_data_out; bus.if_req_in = 1'b0; end
    end
    bus.ls_req_in = 1'b0; bus.if_req_in = 1'b0;
    check($sformatf("contend%0d_ls_at", idx), 32'(ls_at), exp_ls_first ? 32'd2 : 32'd8);
    check($sformatf("contend%0d_if_at", idx), 32'(if_at), exp_ls_first ? 32'd8 : 32'd5);
    check($sformatf("contend%0d_ls_data", idx), ls_d, 32'h0000_0078);
    check($sformatf("contend%0d_if_data", idx), if_d, 32'h0000_0513);
    @(posedge clk); #1;
  endtask

  initial begin
    int seen;
    bus.clear_in = 1'b0; bus.if_req_in = 1'b0; bus.if_addr_in = '0;
    bus.ls_req_in = 1'b0; bus.ls_wr_in = 1'b0; bus.ls_addr_in = '0;
    bus.ls_size_in = '0; bus.ls_wdata_in = '0; bus.io_buffer_full = 1'b0;

    vecs.push_back(mk(0, 0, 32'h100,   3'd4, 32'h0,          0, -1, 5, 32'h0000_0513, 0));
    vecs.push_back(mk(1, 1, 32'h200,   3'd2, 32'hA1B2_C3D4,  0, -1, 2, 32'h0,         2));
    vecs.push_back(mk(1, 0, 32'h100,   3'd1, 32'h0,          0, -1, 2, 32'h0000_0013, 0));
    vecs.push_back(mk(1, 0, 32'h101,   3'd2, 32'h0,          0, -1, 3, 32'h0000_0005, 0));
    vecs.push_back(mk(1, 0, 32'h104,   3'd4, 32'h0,          0, -1, 5, 32'h1234_5678, 0));
    vecs.push_back(mk(1, 0, 32'h104,   3'd3, 32'h0,          0, -1, 5, 32'h1234_5678, 0));
    vecs.push_back(mk(1, 1, 32'h108,   3'd4, 32'hDEAD_BEEF,  0, -1, 4, 32'h0,         4));
    vecs.push_back(mk(1, 0, 32'h108,   3'd4, 32'h0,          0, -1, 5, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk(1, 0, 32'h102,   3'd2, 32'h0,          0, -1, 3, 32'h0000_0000, 0));
    vecs.push_back(mk(1, 1, 32'h30000, 3'd1, 32'h55,         3, -1, 4, 32'h0,         1));
    vecs.push_back(mk(1, 1, 32'h30001, 3'd1, 32'h56,         0, -1, 1, 32'h0,         1));
    vecs.push_back(mk(1, 1, 32'h1FF,   3'd1, 32'h66,         3, -1, 1, 32'h0,         1));
    vecs.push_back(mk(1, 1, 32'h110,   3'd4, 32'h1122_3344,  0,  2, 4, 32'h0,         4));
    vecs.push_back(mk(0, 0, 32'h100,   3'd4, 32'h0,          0,  0, 6, 32'h0000_0513, 0));

    repeat (3) @(posedge clk);
    #1;
    check("reset_mem_a", bus.mem_a, 32'h0);
    check("reset_mem_dout", {24'b0, bus.mem_dout}, 32'h0);
    check("reset_flags", {29'b0, bus.mem_wr, bus.if_done_out, bus.ls_done_out}, 32'h0);
    check("reset_if_data", bus.if_data_out, 32'h0);
    check("reset_ls_rdata", bus.ls_rdata_out, 32'h0);
    @(negedge clk);
    rst = 1'b0; ram_init = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    check("ram_200", {24'b0, ram[10'h200]}, 32'hD4);
    check("ram_201", {24'b0, ram[10'h201]}, 32'hC3);
    check("ram_202", {24'b0, ram[10'h202]}, 32'h00);
    check("ram_1ff", {24'b0, ram[10'h1FF]}, 32'h66);
    check("ram_110_113", {ram[10'h113], ram[10'h112], ram[10'h111], ram[10'h110]}, 32'h1122_3344);

    contend(1'b1, 0);
`ifdef MEM_ARB_RR_EN
    contend(1'b0, 1);
`else
    contend(1'b1, 1);
`endif

    // Flush during an IF read: the access stops, address stays at the last issued byte.
    @(negedge clk);
    bus.if_req_in = 1'b1; bus.if_addr_in = 32'h100;
    repeat (3) @(posedge clk);
    #1;
    bus.clear_in = 1'b1; bus.if_req_in = 1'b0;
    @(posedge clk); #1;
    bus.clear_in = 1'b0;
    check("clear_read_mem_a", bus.mem_a, 32'h102);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.if_done_out || bus.mem_wr) seen++;
      @(posedge clk); #1;
    end
    check("clear_read_no_done", 32'(seen), 32'h0);
    check("clear_read_mem_a_hold", bus.mem_a, 32'h102);

    // Asynchronous reset in the middle of a read.
    @(negedge clk);
    bus.if_req_in = 1'b1; bus.if_addr_in = 32'h104;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_mem_a", bus.mem_a, 32'h106);
    #1 rst = 1'b1;
    #1;
    check("async_rst_mem_a", bus.mem_a, 32'h0);
    check("async_rst_if_data", bus.if_data_out, 32'h0);
    check("async_rst_ls_rdata", bus.ls_rdata_out, 32'h0);
    check("async_rst_flags", {29'b0, bus.mem_wr, bus.if_done_out, bus.ls_done_out}, 32'h0);
    bus.if_req_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_vec(mk(0, 0, 32'h100, 3'd4, 32'h0, 0, -1, 5, 32'h0000_0513, 0), 99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
